// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the button byte and the RX echo stream.
// Latency: request registered at N, grant at N+1, tx_start at N+2.
// Backpressure: tx_busy holds off grants; echo bytes queue in a FIFO, overflow sets sticky echo_ovf.
// Optional feature macro: TX_CRLF_EN (an echoed 0x0D is followed by an LF byte).
module uart_tx_arbiter #(
  parameter int ECHO_DEPTH = 8,
  parameter int TIMEOUT    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_send,
  input  logic [7:0] btn_data,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       echo_en,
  input  logic       ovf_clr,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       echo_full,
  output logic       echo_ovf,
  output logic       last_src
);

  localparam int AW = $clog2(ECHO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3
`ifdef TX_CRLF_EN
    ,
    LF_ISSUE  = 3'd4
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;

  logic          btn_prev, btn_pend;
  logic [7:0]    btn_buf;
  logic          btn_rise;

  logic [7:0]    fifo_mem [ECHO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          echo_empty;
  logic          push_req, push_ok, pop;

  logic          rr_pri;      // 0 = button has priority, 1 = echo has priority
  logic          grant_btn, grant_echo;
  logic          lf_load;

`ifdef TX_CRLF_EN
  logic          crlf_pend;   // current transfer is an echoed CR still owing its LF
`endif

  assign btn_rise   = btn_send & ~btn_prev;
  assign echo_empty = (wr_ptr == rd_ptr);
  assign echo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_req   = rx_valid & echo_en;
  assign pop        = grant_echo;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign push_ok    = push_req & (~echo_full | pop);

  // Button edge detector and single-entry pending buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev <= 1'b0;
      btn_pend <= 1'b0;
      btn_buf  <= 8'h00;
    end else begin
      btn_prev <= btn_send;
      if (grant_btn) begin
        btn_pend <= 1'b0;
      end else if (btn_rise && !btn_pend) begin
        btn_pend <= 1'b1;
        btn_buf  <= btn_data;
      end
    end
  end

  // Echo FIFO pointers, storage and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      echo_ovf <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr[AW-1:0]] <= rx_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_req && !push_ok) begin
        echo_ovf <= 1'b1;
      end else if (ovf_clr) begin
        echo_ovf <= 1'b0;
      end
    end
  end

  // FSM state register and WAIT_BUSY timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT_BUSY) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // Next-state, grant decision and the tx_start strobe.
  always_comb begin
    state_d    = state_q;
    tx_start   = 1'b0;
    grant_btn  = 1'b0;
    grant_echo = 1'b0;
    lf_load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!tx_busy) begin
          if (btn_pend && (echo_empty || !rr_pri)) begin
            grant_btn = 1'b1;
            state_d   = ISSUE;
          end else if (!echo_empty) begin
            grant_echo = 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        tx_start = 1'b1;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
`ifdef TX_CRLF_EN
          if (crlf_pend) begin
            state_d = LF_ISSUE;
            lf_load = 1'b1;
          end
`endif
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
`ifdef TX_CRLF_EN
          if (crlf_pend) begin
            state_d = LF_ISSUE;
            lf_load = 1'b1;
          end
`endif
        end
      end
`ifdef TX_CRLF_EN
      LF_ISSUE: begin
        tx_start = 1'b1;
        state_d  = WAIT_BUSY;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output byte, source tag and round-robin pointer, updated on grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data   <= 8'h00;
      last_src  <= 1'b0;
      rr_pri    <= 1'b0;
`ifdef TX_CRLF_EN
      crlf_pend <= 1'b0;
`endif
    end else begin
      if (grant_btn) begin
        tx_data  <= btn_buf;
        last_src <= 1'b0;
        rr_pri   <= 1'b1;
      end else if (grant_echo) begin
        tx_data  <= fifo_mem[rd_ptr[AW-1:0]];
        last_src <= 1'b1;
        rr_pri   <= 1'b0;
`ifdef TX_CRLF_EN
        crlf_pend <= (fifo_mem[rd_ptr[AW-1:0]] == 8'h0D);
`endif
      end else if (lf_load) begin
        tx_data  <= 8'h0A;
        last_src <= 1'b1;
`ifdef TX_CRLF_EN
        crlf_pend <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model.
// Latency: checks start timing relative to request and busy release.
// Backpressure: model holds tx_busy for a fixed number of cycles per byte.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       reset;
  logic       btn_send;
  logic [7:0] btn_data;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       echo_en;
  logic       ovf_clr;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       echo_full;
  logic       echo_ovf;
  logic       last_src;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // transmitter model controls
  logic model_en  = 1'b1;
  logic hold_busy = 1'b0;
  int   busy_len  = 20;
  int   bcnt      = 0;
  logic start_prev = 1'b0;
  int   last_fall = 0;

  // start log
  int         n_starts = 0;
  logic [7:0] st_dat [$];
  logic       st_src [$];
  int         st_cyc [$];
  int         st_gap [$];

  uart_tx_arbiter #(.ECHO_DEPTH(8), .TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_send  (btn_send),
    .btn_data  (btn_data),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .echo_en   (echo_en),
    .ovf_clr   (ovf_clr),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .echo_full (echo_full),
    .echo_ovf  (echo_ovf),
    .last_src  (last_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor starts first, then advance the transmitter model, all on the falling edge.
  always @(negedge clk) begin
    logic new_busy;
    if (tx_start) begin
      check("start_while_busy", {31'd0, tx_busy}, 32'd0);
      st_dat.push_back(tx_data);
      st_src.push_back(last_src);
      st_cyc.push_back(cyc);
      st_gap.push_back(cyc - last_fall);
      n_starts++;
    end
    if (start_prev && model_en) bcnt = busy_len;
    else if (bcnt > 0) bcnt--;
    new_busy = hold_busy || (model_en && bcnt > 0);
    if (tx_busy && !new_busy) last_fall = cyc;
    tx_busy = new_busy;
    start_prev = tx_start;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (n_starts < n && k < budget) begin
      tick(1);
      k++;
    end
    check("start_count", n_starts, n);
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic press(input logic [7:0] b);
    btn_data = b;
    btn_send = 1'b1;
    tick(2);
    btn_send = 1'b0;
  endtask

  task automatic expect_start(input int idx, input logic [7:0] d, input logic s);
    if (idx < n_starts) begin
      check("start_data", st_dat[idx], d);
      check("start_src", st_src[idx], s);
    end else begin
      check("start_missing", idx, n_starts);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t0;
    reset = 1'b1; btn_send = 1'b0; btn_data = 8'h00;
    rx_valid = 1'b0; rx_data = 8'h00; echo_en = 1'b0; ovf_clr = 1'b0;
    tx_busy = 1'b0;
    tick(3);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_last_src", last_src, 0);
    check("rst_echo_full", echo_full, 0);
    check("rst_echo_ovf", echo_ovf, 0);
    reset = 1'b0;
    tick(2);

    // 1: single button byte, latency 2, one start only
    base = n_starts;
    t0 = cyc;
    press(8'h41);
    wait_starts(base + 1, 40);
    if (n_starts > base) check("btn_latency", st_cyc[base] - t0, 2);
    expect_start(base, 8'h41, 1'b0);
    tick(30);
    check("btn_single_start", n_starts, base + 1);

    // 2: three echo bytes, each started 2 cycles after previous busy fall
    echo_en = 1'b1;
    base = n_starts;
    t0 = cyc;
    push_byte(8'h31); push_byte(8'h32); push_byte(8'h33);
    wait_starts(base + 3, 200);
    if (n_starts > base) check("echo_latency", st_cyc[base] - t0, 2);
    expect_start(base,     8'h31, 1'b1);
    expect_start(base + 1, 8'h32, 1'b1);
    expect_start(base + 2, 8'h33, 1'b1);
    if (n_starts >= base + 3) begin
      check("gap_b2b_1", st_gap[base + 1], 2);
      check("gap_b2b_2", st_gap[base + 2], 2);
    end
    tick(30);

    // 3: simultaneous requests with rr on button, then with rr on echo
    base = n_starts;
    btn_data = 8'h55; btn_send = 1'b1; rx_valid = 1'b1; rx_data = 8'h66;
    tick(1);
    rx_valid = 1'b0;
    tick(1);
    btn_send = 1'b0;
    wait_starts(base + 2, 100);
    expect_start(base,     8'h55, 1'b0);
    expect_start(base + 1, 8'h66, 1'b1);
    tick(30);
    press(8'h11);
    wait_starts(base + 3, 60);
    expect_start(base + 2, 8'h11, 1'b0);
    tick(30);
    btn_data = 8'h99; btn_send = 1'b1; rx_valid = 1'b1; rx_data = 8'hAA;
    tick(1);
    rx_valid = 1'b0;
    tick(1);
    btn_send = 1'b0;
    wait_starts(base + 5, 100);
    expect_start(base + 3, 8'hAA, 1'b1);
    expect_start(base + 4, 8'h99, 1'b0);
    tick(30);

    // 4: fill FIFO under held busy, overflow, clear, then drain in order
    base = n_starts;
    hold_busy = 1'b1;
    tick(2);
    for (int i = 0; i < 9; i++) push_byte(8'hA0 + 8'(i));
    tick(1);
    check("full_set", echo_full, 1);
    check("ovf_set", echo_ovf, 1);
    check("no_start_held", n_starts, base);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", echo_ovf, 0);
    check("full_kept", echo_full, 1);
    hold_busy = 1'b0;
    wait_starts(base + 8, 300);
    for (int i = 0; i < 8; i++) expect_start(base + i, 8'hA0 + 8'(i), 1'b1);
    tick(30);
    check("drain_count", n_starts, base + 8);
    check("full_after_drain", echo_full, 0);

    // 5: busy never rises -> TIMEOUT in WAIT_BUSY between starts
    base = n_starts;
    model_en = 1'b0;
    tick(2);
    push_byte(8'h21); push_byte(8'h22);
    wait_starts(base + 2, 60);
    expect_start(base,     8'h21, 1'b1);
    expect_start(base + 1, 8'h22, 1'b1);
    if (n_starts >= base + 2) check("timeout_gap", st_cyc[base + 1] - st_cyc[base], 6);
    tick(10);
    model_en = 1'b1;
    tick(2);

    // 5b: reset during WAIT_DONE with a full FIFO and overflow pending
    base = n_starts;
    press(8'h77);
    wait_starts(base + 1, 40);
    tick(2);
    for (int i = 0; i < 9; i++) push_byte(8'hC0 + 8'(i));
    check("pre_rst_full", echo_full, 1);
    check("pre_rst_ovf", echo_ovf, 1);
    reset = 1'b1;
    tick(1);
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_last_src", last_src, 0);
    check("mid_rst_full", echo_full, 0);
    check("mid_rst_ovf", echo_ovf, 0);
    reset = 1'b0;
    tick(40);
    check("no_start_after_rst", n_starts, base + 1);

    // 6: echoed CR with a button press during its transfer
    base = n_starts;
    push_byte(8'h0D);
    tick(4);
    press(8'hB5);
`ifdef TX_CRLF_EN
    wait_starts(base + 3, 150);
    expect_start(base,     8'h0D, 1'b1);
    expect_start(base + 1, 8'h0A, 1'b1);
    expect_start(base + 2, 8'hB5, 1'b0);
`else
    wait_starts(base + 2, 150);
    expect_start(base,     8'h0D, 1'b1);
    expect_start(base + 1, 8'hB5, 1'b0);
`endif
    tick(30);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
